instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Two-byte instruction fetch unit: reads low then high byte over a req/ack
// memory port, assembles a 16-bit instruction and offers it with valid/ready.
module instruction_fetch (
    input  logic        CLK,
    input  logic        RST,
    input  logic        En,
    input  logic        PCLoad,
    input  logic [7:0]  PCIn,
    output logic        MemReq,
    output logic [7:0]  MemAddr,
    input  logic        MemAck,
    input  logic [7:0]  MemData,
    output logic        IRValid,
    input  logic        IRReady,
    output logic [15:0] IRout,
    output logic [7:0]  IRPC,
    output logic [7:0]  PCout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  irpc_q, irpc_d;
    logic [15:0] ir_q, ir_d;
    logic        mem_req_q, mem_req_d;
    logic        ir_valid_q, ir_valid_d;
    state_t      restart_s;

    // Next-state and datapath update; redirect overrides every other activity.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        lo_d      = lo_q;
        irpc_d    = irpc_q;
        ir_d      = ir_q;
        restart_s = En ? REQ_LO : IDLE;

        if (PCLoad) begin
            // A pending handshake in HOLD still completes; the redirect just wins the next state.
            pc_d    = PCIn;
            state_d = restart_s;
        end else begin
            case (state_q)
                IDLE: begin
                    if (En) begin
                        state_d = REQ_LO;
                    end else begin
                        state_d = IDLE;
                    end
                end
                REQ_LO: begin
                    if (MemAck) begin
                        lo_d    = MemData;
                        irpc_d  = pc_q;
                        pc_d    = pc_q + 8'd1;
                        state_d = REQ_HI;
                    end else begin
                        state_d = REQ_LO;
                    end
                end
                REQ_HI: begin
                    if (MemAck) begin
                        ir_d    = {MemData, lo_q};
                        pc_d    = pc_q + 8'd1;
                        state_d = HOLD;
                    end else begin
                        state_d = REQ_HI;
                    end
                end
                HOLD: begin
                    if (IRReady) begin
                        state_d = restart_s;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        mem_req_d  = (state_d == REQ_LO) || (state_d == REQ_HI);
        ir_valid_d = (state_d == HOLD);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            pc_q       <= 8'h00;
            lo_q       <= 8'h00;
            irpc_q     <= 8'h00;
            ir_q       <= 16'h0000;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            lo_q       <= lo_d;
            irpc_q     <= irpc_d;
            ir_q       <= ir_d;
            mem_req_q  <= mem_req_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign MemReq  = mem_req_q;
    assign MemAddr = pc_q;
    assign IRValid = ir_valid_q;
    assign IRout   = ir_q;
    assign IRPC    = irpc_q;
    assign PCout   = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, corner-case sequences and
// randomized traffic checked against a byte-count reference model.
module tb_instruction_fetch;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        En = 1'b0;
    logic        PCLoad = 1'b0;
    logic [7:0]  PCIn = 8'h00;
    logic        MemReq;
    logic [7:0]  MemAddr;
    logic        MemAck = 1'b0;
    logic [7:0]  MemData = 8'h00;
    logic        IRValid;
    logic        IRReady = 1'b0;
    logic [15:0] IRout;
    logic [7:0]  IRPC;
    logic [7:0]  PCout;

    instruction_fetch dut (
        .CLK(CLK), .RST(RST), .En(En), .PCLoad(PCLoad), .PCIn(PCIn),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
        .IRValid(IRValid), .IRReady(IRReady), .IRout(IRout), .IRPC(IRPC),
        .PCout(PCout)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [256];

    // Reference model: number of bytes collected so far plus a busy flag.
    logic [7:0]  m_pc;
    int          m_n;
    logic        m_busy;
    logic [7:0]  m_lo;
    logic [15:0] m_ir;
    logic [7:0]  m_irpc;

    typedef struct {
        logic        en;
        logic        pl;
        logic [7:0]  pcin;
        logic        ack;
        logic [7:0]  data;
        logic        ready;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_valid;
        logic [15:0] e_ir;
        logic [7:0]  e_irpc;
        logic [7:0]  e_pc;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 8'h00;
        m_n    = 0;
        m_busy = 1'b0;
        m_lo   = 8'h00;
        m_ir   = 16'h0000;
        m_irpc = 8'h00;
    endtask

    task automatic model_update(input logic en, input logic pl, input logic [7:0] pcin,
                                input logic ack, input logic ready);
        if (pl) begin
            m_pc   = pcin;
            m_n    = 0;
            m_busy = en;
        end else if (m_n == 2) begin
            if (ready) begin
                m_n    = 0;
                m_busy = en;
            end
        end else if (m_busy) begin
            if (ack) begin
                if (m_n == 0) begin
                    m_lo   = mem[m_pc];
                    m_irpc = m_pc;
                end else begin
                    m_ir = {mem[m_pc], m_lo};
                end
                m_pc = m_pc + 8'd1;
                m_n  = m_n + 1;
            end
        end else begin
            m_busy = en;
        end
    endtask

    task automatic check_model();
        logic m_req;
        logic m_valid;
        m_req   = m_busy && (m_n < 2);
        m_valid = (m_n == 2);
        chk("memreq", {15'd0, MemReq}, {15'd0, m_req});
        chk("irvalid", {15'd0, IRValid}, {15'd0, m_valid});
        chk("pcout", {8'd0, PCout}, {8'd0, m_pc});
        if (m_req) chk("memaddr", {8'd0, MemAddr}, {8'd0, m_pc});
        if (m_valid) begin
            chk("irout", IRout, m_ir);
            chk("irpc", {8'd0, IRPC}, {8'd0, m_irpc});
        end
    endtask

    task automatic step(input logic en, input logic pl, input logic [7:0] pcin,
                        input logic ack, input logic ready);
        En      = en;
        PCLoad  = pl;
        PCIn    = pcin;
        MemAck  = ack;
        IRReady = ready;
        MemData = ack ? mem[MemAddr] : 8'($urandom);
        @(posedge CLK);
        model_update(en, pl, pcin, ack, ready);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #2;
        model_reset();
        chk("rst_memreq", {15'd0, MemReq}, 16'h0000);
        chk("rst_memaddr", {8'd0, MemAddr}, 16'h0000);
        chk("rst_irvalid", {15'd0, IRValid}, 16'h0000);
        chk("rst_irout", IRout, 16'h0000);
        chk("rst_irpc", {8'd0, IRPC}, 16'h0000);
        chk("rst_pcout", {8'd0, PCout}, 16'h0000);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34;
        mem[1] = 8'h12;

        //          en    pl    pcin   ack   data   rdy  | req   addr   vld   ir        irpc   pc
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h34, 1'b1, 1'b1, 8'h01, 1'b0, 16'h0000, 8'h00, 8'h01};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 8'h02};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 8'h02};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 8'h02};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 8'h02};
        tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 8'h02};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 8'h02};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 16'h0000, 8'h00, 8'h02};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hCD, 1'b0, 1'b1, 8'h03, 1'b0, 16'h0000, 8'h00, 8'h03};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 16'h0000, 8'h00, 8'h03};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hAB, 1'b0, 1'b0, 8'h00, 1'b1, 16'hABCD, 8'h02, 8'h04};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h04};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h04};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 16'h0000, 8'h00, 8'h04};
        tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b1, 8'h05, 1'b0, 16'h0000, 8'h00, 8'h05};
        tbl[16] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'h22, 1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000, 8'h00, 8'hFF};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h56, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00};
        tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h78, 1'b0, 1'b0, 8'h00, 1'b1, 16'h7856, 8'hFF, 8'h01};
        tbl[19] = '{1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 16'h0000, 8'h00, 8'h40};
        tbl[20] = '{1'b0, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h80};

        #1;
        do_reset();

        for (int i = 0; i < 21; i++) begin
            En      = tbl[i].en;
            PCLoad  = tbl[i].pl;
            PCIn    = tbl[i].pcin;
            MemAck  = tbl[i].ack;
            MemData = tbl[i].data;
            IRReady = tbl[i].ready;
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d_memreq", i), {15'd0, MemReq}, {15'd0, tbl[i].e_req});
            chk($sformatf("tbl%0d_irvalid", i), {15'd0, IRValid}, {15'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_pcout", i), {8'd0, PCout}, {8'd0, tbl[i].e_pc});
            if (tbl[i].e_req) chk($sformatf("tbl%0d_memaddr", i), {8'd0, MemAddr}, {8'd0, tbl[i].e_addr});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_irout", i), IRout, tbl[i].e_ir);
                chk($sformatf("tbl%0d_irpc", i), {8'd0, IRPC}, {8'd0, tbl[i].e_irpc});
            end
        end

        // Two wait cycles per byte: address held, valid only after the second ack.
        do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int b = 0; b < 2; b++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            chk("wait_addr_held", {7'd0, MemReq, MemAddr}, {7'd0, 1'b1, 8'(b)});
            step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            chk("wait_addr_held", {7'd0, MemReq, MemAddr}, {7'd0, 1'b1, 8'(b)});
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wait_irvalid", {15'd0, IRValid}, 16'h0001);
        chk("wait_irout", IRout, 16'h1234);

        // Asynchronous reset in the middle of a high-byte request.
        do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        MemAck = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            chk("post_rst_idle", {15'd0, MemReq}, 16'h0000);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, 24) == 0,
                     8'($urandom),
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 4) < 3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
